// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-order helpers for the inverse round datapath.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR_128      = 10;
  localparam int NR_192      = 12;
  localparam int NR_256      = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

  // Byte 0 sits in the most significant byte of the block.
  function automatic int byte_lsb(input int idx);
    return AES_BLOCK_W - 8 - 8 * idx;
  endfunction

  function automatic logic [AES_BLOCK_W-1:0] inv_shift_rows(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[byte_lsb(4 * c + r) +: 8] = s[byte_lsb(4 * ((c - r + 4) % 4) + r) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round_iter_if.sv
// Ciphertext/plaintext handshakes, round-key fetch and status of the inverse round engine.
interface aes_inv_round_iter_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] ciphertext;
  logic [3:0]             rk_idx;
  logic [AES_BLOCK_W-1:0] rk_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] plaintext;
  logic                   busy;

  modport master (
    output in_valid, ciphertext, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, plaintext, busy
  );

  modport slave (
    input  in_valid, ciphertext, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, plaintext, busy
  );
endinterface

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, purely combinational byte lookup.
module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] q_o
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 is the top byte, so the bit offset is (255 - a) * 8.
  assign q_o = INV_SBOX[{~a_i, 3'b000} +: 8];

endmodule

// File: rtl/inv_mixcolumns.sv
// AES InvMixColumns over a full 128-bit state, one GF(2^8) matrix product per column.
module inv_mixcolumns
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_i,
  output logic [AES_BLOCK_W-1:0] state_o
);

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = state_i[byte_lsb(4 * c + 0) +: 8];
    assign a1 = state_i[byte_lsb(4 * c + 1) +: 8];
    assign a2 = state_i[byte_lsb(4 * c + 2) +: 8];
    assign a3 = state_i[byte_lsb(4 * c + 3) +: 8];

    assign state_o[byte_lsb(4 * c + 0) +: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
    assign state_o[byte_lsb(4 * c + 1) +: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
    assign state_o[byte_lsb(4 * c + 2) +: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
    assign state_o[byte_lsb(4 * c + 3) +: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
  end

endmodule

// File: rtl/aes_inv_round_iter.sv
// Iterative AES inverse cipher, one round per clock; round keys are fetched by index from an external store.
//   state | meaning
//   IDLE  | waiting for ciphertext, initial AddRoundKey with key NR on accept
//   ROUND | middle rounds NR-1..1 through InvMixColumns
//   FINAL | last round without InvMixColumns, result registered
//   DONE  | plaintext held until the consumer takes it
module aes_inv_round_iter
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input logic clk,
  input logic rst,
  aes_inv_round_iter_if.slave bus
);

  localparam logic [3:0] NR_L = 4'(NR);

  aes_state_e             state_q;
  logic [3:0]             round_q;
  logic [AES_BLOCK_W-1:0] state_reg_q;
  logic [AES_BLOCK_W-1:0] plaintext_q;
  logic                   out_valid_q;

  logic [AES_BLOCK_W-1:0] isr, sub, addk, imc;

  // ROUND and FINAL share the same InvShiftRows/InvSubBytes/AddRoundKey front end.
  assign isr = inv_shift_rows(state_reg_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a_i(isr[8*i +: 8]),
      .q_o(sub[8*i +: 8])
    );
  end

  assign addk = sub ^ bus.rk_data;

  inv_mixcolumns u_imc (
    .state_i(addk),
    .state_o(imc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= '0;
      state_reg_q <= '0;
      plaintext_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg_q <= bus.ciphertext ^ bus.rk_data;
            round_q     <= NR_L - 4'd1;
            state_q     <= ROUND;
          end
        end
        ROUND: begin
          state_reg_q <= imc;
          if (round_q == 4'd1) state_q <= FINAL;
          else round_q <= round_q - 4'd1;
        end
        FINAL: begin
          plaintext_q <= addk;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rk_idx    = (state_q == IDLE) ? NR_L : (state_q == ROUND) ? round_q : 4'd0;
  assign bus.out_valid = out_valid_q;
  assign bus.plaintext = plaintext_q;

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Self-checking bench for aes_inv_round_iter: FIPS-197 vectors for NR=10 and NR=14 with a plaintext scoreboard.
module tb_aes_inv_round_iter;
  import aes_pkg::*;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_inv_round_iter_if ifa ();
  aes_inv_round_iter_if ifb ();

  logic [127:0] rk_a   [0:15];
  logic [127:0] rk_b   [0:15];
  logic [127:0] rk_tmp [0:15];
  logic [31:0]  w      [0:63];
  logic [127:0] exp_q  [$];

  int n_checks = 0;
  int n_pass   = 0;

  assign ifa.rk_data = rk_a[ifa.rk_idx];
  assign ifb.rk_data = rk_b[ifb.rk_idx];

  aes_inv_round_iter #(.NR(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  aes_inv_round_iter #(.NR(14)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2040 - 8 * int'(b) +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // FIPS-197 key expansion into rk_tmp[0..nk+6].
  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [7:0]  rc;
    logic [31:0] t;
    int          nw;
    rc = 8'h01;
    nw = 4 * (nk + 7);
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32 * i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) rk_tmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic set_key_a(input logic [127:0] key);
    expand_key({key, 128'h0}, 4);
    for (int r = 0; r < 16; r++) rk_a[r] = rk_tmp[r];
  endtask

  // Presents one block for a single cycle; caller ensures the DUT is idle. Leaves at accept edge + 1.
  task automatic drive_block(input bit sel, input logic [127:0] ct, input logic [127:0] pt);
    if (sel) begin ifb.ciphertext = ct; ifb.in_valid = 1'b1; end
    else     begin ifa.ciphertext = ct; ifa.in_valid = 1'b1; end
    @(posedge clk); #1;
    if (sel) ifb.in_valid = 1'b0;
    else     ifa.in_valid = 1'b0;
    exp_q.push_back(pt);
  endtask

  // Counts further rising edges until out_valid, bounded by budget.
  task automatic wait_out(input bit sel, input int budget, output int edges);
    edges = 0;
    while (!(sel ? ifb.out_valid : ifa.out_valid) && edges < budget) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic take_out(input bit sel);
    if (sel) ifb.out_ready = 1'b1; else ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    if (sel) ifb.out_ready = 1'b0; else ifa.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ifa.in_ready); else n_pass++;
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.plaintext !== 128'h0) $display("FAIL reset_plaintext: got %h want 0", ifa.plaintext); else n_pass++;
    n_checks++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifa.busy); else n_pass++;
    n_checks++; if (ifa.rk_idx !== 4'd10) $display("FAIL reset_rk_idx: got %0d want 10", ifa.rk_idx); else n_pass++;
    n_checks++; if (ifb.rk_idx !== 4'd14) $display("FAIL reset_rk_idx_nr14: got %0d want 14", ifb.rk_idx); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vec_appb();
    int edges;
    logic [127:0] exp;
    set_key_a(KEY_B);
    drive_block(1'b0, CT_B, PT_B);
    wait_out(1'b0, 40, edges);
    n_checks++; if (edges !== 10) $display("FAIL appb_latency: got %0d edges want 11", edges + 1); else n_pass++;
    n_checks++; if (ifa.in_ready !== 1'b0) $display("FAIL appb_in_ready_done: got %b want 0", ifa.in_ready); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if (ifa.plaintext !== exp) $display("FAIL appb_plaintext: got %h want %h", ifa.plaintext, exp); else n_pass++;
    take_out(1'b0);
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL appb_out_valid_after_take: got %b want 0", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL appb_in_ready_after_take: got %b want 1", ifa.in_ready); else n_pass++;
  endtask

  task automatic test_c1_rkidx();
    int edges;
    logic [127:0] exp;
    set_key_a(KEY_C1);
    ifa.ciphertext = CT_C1;
    ifa.in_valid   = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      n_checks++;
      if (ifa.rk_idx !== 4'(10 - k)) $display("FAIL c1_rk_idx step %0d: got %0d want %0d", k, ifa.rk_idx, 10 - k);
      else n_pass++;
      @(posedge clk); #1;
      if (k == 0) begin
        ifa.in_valid = 1'b0;
        exp_q.push_back(PT_C);
      end
    end
    wait_out(1'b0, 5, edges);
    n_checks++; if (edges !== 0) $display("FAIL c1_latency: got %0d edges want 11", edges + 11); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if (ifa.plaintext !== exp) $display("FAIL c1_plaintext: got %h want %h", ifa.plaintext, exp); else n_pass++;
    take_out(1'b0);
  endtask

  task automatic test_backpressure();
    int edges;
    logic [127:0] exp;
    set_key_a(KEY_B);
    drive_block(1'b0, CT_B, PT_B);
    wait_out(1'b0, 40, edges);
    for (int k = 0; k < 20; k++) begin
      n_checks++; if (ifa.out_valid !== 1'b1) $display("FAIL bp_out_valid cycle %0d: got %b want 1", k, ifa.out_valid); else n_pass++;
      n_checks++; if (ifa.plaintext !== exp_q[0]) $display("FAIL bp_plaintext cycle %0d: got %h want %h", k, ifa.plaintext, exp_q[0]); else n_pass++;
      n_checks++; if (ifa.in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d: got %b want 0", k, ifa.in_ready); else n_pass++;
      @(posedge clk); #1;
    end
    void'(exp_q.pop_front());
    take_out(1'b0);
    n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL bp_in_ready_after_take: got %b want 1", ifa.in_ready); else n_pass++;
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL bp_out_valid_after_take: got %b want 0", ifa.out_valid); else n_pass++;
    set_key_a(KEY_C1);
    drive_block(1'b0, CT_C1, PT_C);
    wait_out(1'b0, 40, edges);
    n_checks++; if (edges !== 10) $display("FAIL bp_second_latency: got %0d edges want 11", edges + 1); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if (ifa.plaintext !== exp) $display("FAIL bp_second_plaintext: got %h want %h", ifa.plaintext, exp); else n_pass++;
    take_out(1'b0);
  endtask

  task automatic test_busy_ignore();
    int edges;
    logic [127:0] exp;
    set_key_a(KEY_B);
    drive_block(1'b0, CT_B, PT_B);
    for (int k = 0; k < 8; k++) begin
      ifa.ciphertext = {$urandom, $urandom, $urandom, $urandom};
      ifa.in_valid   = (k % 2 == 0);
      n_checks++; if (ifa.in_ready !== 1'b0) $display("FAIL busy_in_ready cycle %0d: got %b want 0", k, ifa.in_ready); else n_pass++;
      @(posedge clk); #1;
    end
    ifa.in_valid = 1'b0;
    wait_out(1'b0, 20, edges);
    n_checks++; if (edges !== 2) $display("FAIL busy_latency: got %0d edges want 11", edges + 9); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if (ifa.plaintext !== exp) $display("FAIL busy_plaintext: got %h want %h", ifa.plaintext, exp); else n_pass++;
    take_out(1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++; if (ifa.busy !== 1'b0) $display("FAIL busy_no_spurious_accept: got %b want 0", ifa.busy); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    logic [127:0] exp;
    set_key_a(KEY_B);
    drive_block(1'b0, CT_B, PT_B);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", ifa.in_ready); else n_pass++;
    n_checks++; if (ifa.rk_idx !== 4'd10) $display("FAIL rstmid_rk_idx: got %0d want 10", ifa.rk_idx); else n_pass++;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    // Reset while a finished block is held: the result must vanish at once.
    set_key_a(KEY_C1);
    drive_block(1'b0, CT_C1, PT_C);
    wait_out(1'b0, 40, edges);
    n_checks++; if (ifa.out_valid !== 1'b1) $display("FAIL rstdone_reached_done: got %b want 1", ifa.out_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL rstdone_out_valid: got %b want 0", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.plaintext !== 128'h0) $display("FAIL rstdone_plaintext: got %h want 0", ifa.plaintext); else n_pass++;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    drive_block(1'b0, CT_C1, PT_C);
    wait_out(1'b0, 40, edges);
    n_checks++; if (edges !== 10) $display("FAIL rstmid_after_latency: got %0d edges want 11", edges + 1); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if (ifa.plaintext !== exp) $display("FAIL rstmid_after_plaintext: got %h want %h", ifa.plaintext, exp); else n_pass++;
    take_out(1'b0);
  endtask

  task automatic test_nr14();
    int edges;
    logic [127:0] exp;
    expand_key(KEY_C3, 8);
    for (int r = 0; r < 16; r++) rk_b[r] = rk_tmp[r];
    drive_block(1'b1, CT_C3, PT_C);
    wait_out(1'b1, 60, edges);
    n_checks++; if (edges !== 14) $display("FAIL nr14_latency: got %0d edges want 15", edges + 1); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if (ifb.plaintext !== exp) $display("FAIL nr14_plaintext: got %h want %h", ifb.plaintext, exp); else n_pass++;
    take_out(1'b1);
    n_checks++; if (ifb.in_ready !== 1'b1) $display("FAIL nr14_in_ready_after_take: got %b want 1", ifb.in_ready); else n_pass++;
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.ciphertext = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.ciphertext = '0; ifb.out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      rk_a[r] = '0;
      rk_b[r] = '0;
    end
    test_reset();
    test_vec_appb();
    test_c1_rkidx();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_nr14();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 ns, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
